// File: rtl/sdram_master_arb.sv
// Purpose: round-robin share of one SDRAM Avalon-MM master among N_REQ accelerator masters; read responses return in order via a tag FIFO.
// Latency: 1 cycle arbitration (IDLE) then combinational forwarding while granted; read data/valid routed combinationally to the issuer.
// Backpressure: m_waitrequest, or a full tag FIFO for reads, holds the granted requester; others see waitrequest. Optional macro ARB_HOLD_EN keeps the grant for streaming.
module sdram_master_arb #(
  parameter int N_REQ     = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ*AW-1:0]          r_address,
  input  logic [N_REQ-1:0]             r_read,
  input  logic [N_REQ-1:0]             r_write,
  input  logic [N_REQ*DW-1:0]          r_writedata,
  output logic [N_REQ-1:0]             r_waitrequest,
  output logic [DW-1:0]                r_readdata,
  output logic [N_REQ-1:0]             r_readdatavalid,
  output logic [AW-1:0]                m_address,
  output logic                         m_read,
  output logic                         m_write,
  output logic [DW-1:0]                m_writedata,
  input  logic                         m_waitrequest,
  input  logic [DW-1:0]                m_readdata,
  input  logic                         m_readdatavalid,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         rsp_err
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   idx;
  logic [N_REQ-1:0] req;
  logic            gnt_rd, gnt_wr, gnt_req;
  logic            accept, push, pop;
  logic            fifo_full, fifo_empty;

  logic [GW-1:0]   tag_q [MAX_OUTST];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            rsp_err_q;

`ifdef ARB_HOLD_EN
  // Number of accepts made under the current grant; nonzero also marks that last must move on release.
  logic [5:0]      hold_cnt_q, hold_cnt_d;
`endif

  // A read+write requester counts once; the read wins later.
  assign req        = r_read | r_write;
  assign gnt_rd     = r_read[grant_q];
  assign gnt_wr     = r_write[grant_q];
  assign gnt_req    = req[grant_q];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(MAX_OUTST));

  // Round-robin search starting just after the last served requester; the descending loop lets the nearest one win.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_q) + k) % N_REQ);
      if (req[idx]) pick = idx;
    end
  end

  // Arbitration FSM next state plus combinational forwarding of the granted requester to the SDRAM port.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    m_address     = '0;
    m_writedata   = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    r_waitrequest = '1;
    accept        = 1'b0;
    push          = 1'b0;
`ifdef ARB_HOLD_EN
    hold_cnt_d    = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_HOLD_EN
        hold_cnt_d = '0;
`endif
        if (|req) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_q == GW'(i)) begin
            m_address   = r_address[i*AW +: AW];
            m_writedata = r_writedata[i*DW +: DW];
          end
        end
        m_read  = gnt_rd & ~fifo_full;
        m_write = gnt_wr & ~gnt_rd;
        r_waitrequest[grant_q] = m_waitrequest | (gnt_rd & fifo_full);
        accept  = (m_read | m_write) & ~m_waitrequest;
        push    = m_read & ~m_waitrequest;
`ifdef ARB_HOLD_EN
        if (!gnt_req) begin
          // Release: move priority on only if this grant actually did work.
          state_d    = IDLE;
          hold_cnt_d = '0;
          if (hold_cnt_q != '0) last_d = grant_q;
        end else if (accept) begin
          if (hold_cnt_q == 6'd63) begin
            state_d    = IDLE;
            last_d     = grant_q;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 6'd1;
          end
        end
`else
        if (!gnt_req) begin
          // Requester withdrew before being served: keep its priority position.
          state_d = IDLE;
        end else if (accept) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers; last starts at N_REQ-1 so requester 0 is first after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_REQ - 1);
`ifdef ARB_HOLD_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef ARB_HOLD_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  // A response is only routable if a tag is waiting; the full check uses the pre-pop count.
  assign pop = m_readdatavalid & ~fifo_empty;

  // Route readdatavalid to the requester at the head of the tag FIFO.
  always_comb begin
    r_readdatavalid = '0;
    if (pop) r_readdatavalid[tag_q[rd_ptr_q]] = 1'b1;
  end

  assign r_readdata = m_readdata;

  // Tag storage needs no reset; stale entries are never read past the pointers.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= grant_q;
  end

  // Tag FIFO pointers, occupancy and sticky orphan-response flag; reset drops all in-flight tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (m_readdatavalid && fifo_empty) rsp_err_q <= 1'b1;
    end
  end

  assign outst_cnt = cnt_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sdram_master_arb.sv
// Purpose: directed bench for sdram_master_arb with a scoreboard of expected SDRAM-side accepts and read responses.
// Latency: stimulus driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: bench drives m_waitrequest directly; every wait is bounded.
module tb_sdram_master_arb;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*AW-1:0] r_address = '0;
  logic [N-1:0]    r_read = '0;
  logic [N-1:0]    r_write = '0;
  logic [N*DW-1:0] r_writedata = '0;
  logic [N-1:0]    r_waitrequest;
  logic [DW-1:0]   r_readdata;
  logic [N-1:0]    r_readdatavalid;
  logic [AW-1:0]   m_address;
  logic            m_read;
  logic            m_write;
  logic [DW-1:0]   m_writedata;
  logic            m_waitrequest = 1'b0;
  logic [DW-1:0]   m_readdata = '0;
  logic            m_readdatavalid = 1'b0;
  logic [2:0]      outst_cnt;
  logic            rsp_err;

  sdram_master_arb #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r_address(r_address), .r_read(r_read), .r_write(r_write), .r_writedata(r_writedata),
    .r_waitrequest(r_waitrequest), .r_readdata(r_readdata), .r_readdatavalid(r_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .outst_cnt(outst_cnt), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdat;
    int          req;
  } mst_t;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] dat;
  } rsp_t;

  mst_t mst_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  mst_t me;
  rsp_t re;
  logic [3:0] wexp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every SDRAM-side accept and every routed response is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (m_read || m_write) && !m_waitrequest) begin
      acc_cnt++;
      if (mst_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mst_unexpected: got addr %0h, want no transaction", m_address);
      end else begin
        me = mst_q.pop_front();
        wexp = ~(4'b0001 << me.req);
        chk("mst_read", m_read, me.rd);
        chk("mst_write", m_write, !me.rd);
        chk("mst_addr", m_address, me.addr);
        if (!me.rd) chk("mst_wdata", m_writedata, me.wdat);
        chk("mst_grant_wreq", r_waitrequest, wexp);
      end
    end
    if (|r_readdatavalid) begin
      if (rsp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rdv %b, want none", r_readdatavalid);
      end else begin
        re = rsp_q.pop_front();
        chk("rsp_vld", r_readdatavalid, re.vld);
        chk("rsp_data", r_readdata, re.dat);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input int i, input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    mst_t e;
    bit ok;
    ok = 1'b0;
    e.rd = rd; e.addr = addr; e.wdat = wd; e.req = i;
    mst_q.push_back(e);
    r_address[i*AW +: AW]   = addr;
    r_writedata[i*DW +: DW] = wd;
    r_read[i]  = rd;
    r_write[i] = wr;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!r_waitrequest[i]) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL issue_timeout: req %0d got waitrequest stuck, want accept", i);
    end
    @(posedge clk); #1;
    r_read[i]  = 1'b0;
    r_write[i] = 1'b0;
  endtask

  // One-cycle SDRAM response; expected routing vector pushed to the scoreboard.
  task automatic respond(input logic [31:0] d, input logic [3:0] vexp);
    rsp_t e;
    e.vld = vexp; e.dat = d;
    rsp_q.push_back(e);
    m_readdatavalid = 1'b1;
    m_readdata = d;
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tgt;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wreq", r_waitrequest, 4'hF);
    chk("rst_rdv", r_readdatavalid, 4'h0);
    chk("rst_mread", m_read, 1'b0);
    chk("rst_mwrite", m_write, 1'b0);
    chk("rst_outst", outst_cnt, 3'd0);
    chk("rst_err", rsp_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single read from requester 0
    fork
      issue(0, 1'b1, 1'b0, 32'h100, 32'h0);
      begin
        @(negedge clk);
        chk("t1_idle_mread", m_read, 1'b0);
        @(negedge clk);
        chk("t1_mread", m_read, 1'b1);
        chk("t1_addr", m_address, 32'h100);
        chk("t1_wreq", r_waitrequest, 4'b1110);
      end
    join
    @(negedge clk);
    chk("t1_outst1", outst_cnt, 3'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    respond(32'h2A, 4'b0001);
    @(negedge clk);
    chk("t1_outst0", outst_cnt, 3'd0);

    // Round robin with all four writing continuously
    @(posedge clk); #1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      mst_t e;
      e.rd = 1'b0; e.req = k % 4;
      e.addr = 32'h1000 + 32'(k % 4) * 32'h10;
      e.wdat = 32'hD0 + 32'(k % 4);
      mst_q.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      r_address[i*AW +: AW]   = 32'h1000 + 32'(i) * 32'h10;
      r_writedata[i*DW +: DW] = 32'hD0 + 32'(i);
    end
    tgt = acc_cnt + 5;
    r_write = 4'hF;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      if (acc_cnt >= tgt) break;
    end
    #1;
    r_write = 4'h0;
    repeat (3) @(negedge clk);
    chk("t2_accepts", acc_cnt, tgt);

    // Write held off by SDRAM waitrequest for 5 cycles
    @(posedge clk); #1;
    m_waitrequest = 1'b1;
    fork
      issue(2, 1'b0, 1'b1, 32'h2000, 32'hBEEF);
      begin
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("t3_mwrite", m_write, 1'b1);
          chk("t3_addr", m_address, 32'h2000);
          chk("t3_wreq", r_waitrequest, 4'hF);
        end
        @(posedge clk); #1;
        m_waitrequest = 1'b0;
      end
    join

    // In-order response routing
    issue(1, 1'b1, 1'b0, 32'h10, 32'h0);
    issue(3, 1'b1, 1'b0, 32'h20, 32'h0);
    issue(0, 1'b1, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    chk("t4_outst3", outst_cnt, 3'd3);
    @(posedge clk); #1;
    respond(32'hA, 4'b0010);
    respond(32'hB, 4'b1000);
    respond(32'hC, 4'b0001);
    @(negedge clk);
    chk("t4_outst0", outst_cnt, 3'd0);

    // Read+write from one requester is served as a read
    @(posedge clk); #1;
    issue(1, 1'b1, 1'b1, 32'h60, 32'h99);
    respond(32'h5, 4'b0010);

    // Tag FIFO full: fifth read stalls until one response drains
    issue(0, 1'b1, 1'b0, 32'h40, 32'h0);
    issue(1, 1'b1, 1'b0, 32'h41, 32'h0);
    issue(2, 1'b1, 1'b0, 32'h42, 32'h0);
    issue(3, 1'b1, 1'b0, 32'h43, 32'h0);
    fork
      issue(0, 1'b1, 1'b0, 32'h50, 32'h0);
      begin
        repeat (3) @(negedge clk);
        chk("t5_full_mread", m_read, 1'b0);
        chk("t5_full_wreq", r_waitrequest, 4'hF);
        chk("t5_full_outst", outst_cnt, 3'd4);
        @(posedge clk); #1;
        respond(32'h11, 4'b0001);
        @(negedge clk);
        chk("t5_outst3", outst_cnt, 3'd3);
        chk("t5_mread", m_read, 1'b1);
        @(negedge clk);
        chk("t5_outst4", outst_cnt, 3'd4);
      end
    join
    respond(32'h12, 4'b0010);
    respond(32'h13, 4'b0100);
    respond(32'h14, 4'b1000);
    respond(32'h15, 4'b0001);
    @(negedge clk);
    chk("t5_drained", outst_cnt, 3'd0);

    // Reset drops an in-flight tag; the late response is an orphan
    @(posedge clk); #1;
    issue(2, 1'b1, 1'b0, 32'h70, 32'h0);
    do_reset();
    @(negedge clk);
    chk("t6_outst_after_rst", outst_cnt, 3'd0);
    @(posedge clk); #1;
    m_readdatavalid = 1'b1;
    m_readdata = 32'h77;
    @(negedge clk);
    chk("t6_orphan_rdv", r_readdatavalid, 4'h0);
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
    @(negedge clk);
    chk("t6_err_set", rsp_err, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_err_sticky", rsp_err, 1'b1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("t6_err_clear", rsp_err, 1'b0);

    repeat (2) @(negedge clk);
    chk("mst_q_empty", mst_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
